// File: rtl/tour_cmd_seq.sv
// Turns a solved knight's tour into motion commands: each move becomes a vertical leg and then a horizontal leg.
// Optional macro TOUR_CMD_ERR_EN adds the tour_err output, which aborts the tour when a move is not one-hot.
module tour_cmd_seq #(
    parameter int         NUM_MOVES = 24,
    parameter logic [7:0] HDG_N     = 8'h00,
    parameter logic [7:0] HDG_W     = 8'h3F,
    parameter logic [7:0] HDG_S     = 8'h7F,
    parameter logic [7:0] HDG_E     = 8'hBF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic        clr_cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    output logic [7:0]  resp,
    output logic        tour_done,
`ifdef TOUR_CMD_ERR_EN
    output logic        tour_err,
`endif
    output logic [2:0]  state_dbg
);

    // Handshake: cmd is valid while cmd_rdy is high. clr_cmd_rdy accepts it, and send_resp
    // reports that it has finished executing. The next leg goes out one cycle after send_resp.

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VERT   = 3'd1,
        WAIT_V = 3'd2,
        HORZ   = 3'd3,
        WAIT_H = 3'd4
    } state_t;

    localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);
    localparam logic [3:0] OP_MOVE   = 4'b0010;
    localparam logic [3:0] OP_FANF   = 4'b0011;

    state_t state, nxt_state;

    logic signed [2:0] dx, dy;
    logic [2:0]        abs_x, abs_y;
    logic [7:0]        hdg_x, hdg_y;
    logic [15:0]       vert_cmd, horz_cmd;
    logic              last_move;
    logic              indx_clr, indx_inc, done_set;
`ifdef TOUR_CMD_ERR_EN
    logic              move_ok;
    logic              err_set;
`endif

    // Solver encoding: each one-hot bit selects one (dx, dy) knight offset.
    always_comb begin
        dx = 3'sd0;
        dy = 3'sd0;
        case (move)
            8'h01: begin dx = -3'sd1; dy =  3'sd2; end
            8'h02: begin dx =  3'sd1; dy =  3'sd2; end
            8'h04: begin dx = -3'sd2; dy =  3'sd1; end
            8'h08: begin dx = -3'sd2; dy = -3'sd1; end
            8'h10: begin dx = -3'sd1; dy = -3'sd2; end
            8'h20: begin dx =  3'sd1; dy = -3'sd2; end
            8'h40: begin dx =  3'sd2; dy = -3'sd1; end
            8'h80: begin dx =  3'sd2; dy =  3'sd1; end
            default: begin dx = 3'sd0; dy = 3'sd0; end
        endcase
    end

    // A zero offset counts as non-negative, so its leg is headed N/E with zero squares.
    assign abs_x    = dx[2] ? -dx : dx;
    assign abs_y    = dy[2] ? -dy : dy;
    assign hdg_x    = dx[2] ? HDG_W : HDG_E;
    assign hdg_y    = dy[2] ? HDG_S : HDG_N;
    assign vert_cmd = {OP_MOVE, hdg_y, 1'b0, abs_y};
    assign horz_cmd = {OP_FANF, hdg_x, 1'b0, abs_x};
    assign last_move = (mv_indx == LAST_INDX);

`ifdef TOUR_CMD_ERR_EN
    assign move_ok = (move != 8'h00) && ((move & (move - 8'd1)) == 8'h00);
`endif

    always_comb begin
        nxt_state = state;
        indx_clr  = 1'b0;
        indx_inc  = 1'b0;
        done_set  = 1'b0;
`ifdef TOUR_CMD_ERR_EN
        err_set   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start_tour) begin
                    nxt_state = VERT;
                    indx_clr  = 1'b1;
                end
            end
            VERT: begin
`ifdef TOUR_CMD_ERR_EN
                if (!move_ok) begin
                    nxt_state = IDLE;
                    err_set   = 1'b1;
                end else if (clr_cmd_rdy) begin
                    nxt_state = WAIT_V;
                end
`else
                if (clr_cmd_rdy) nxt_state = WAIT_V;
`endif
            end
            WAIT_V: begin
                if (send_resp) nxt_state = HORZ;
            end
            HORZ: begin
                if (clr_cmd_rdy) nxt_state = WAIT_H;
            end
            WAIT_H: begin
                if (send_resp) begin
                    if (last_move) begin
                        nxt_state = IDLE;
                        done_set  = 1'b1;
                    end else begin
                        nxt_state = VERT;
                        indx_inc  = 1'b1;
                    end
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    // The UART path owns cmd/cmd_rdy/clr only while no tour is in progress.
    always_comb begin
        cmd              = cmd_UART;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        resp             = 8'h5A;
        case (state)
            IDLE: begin
                cmd_rdy          = cmd_rdy_UART;
                clr_cmd_rdy_UART = clr_cmd_rdy;
                resp             = 8'hA5;
            end
            VERT: begin
                cmd = vert_cmd;
`ifdef TOUR_CMD_ERR_EN
                cmd_rdy = move_ok;
`else
                cmd_rdy = 1'b1;
`endif
            end
            WAIT_V: begin
                cmd = vert_cmd;
            end
            HORZ: begin
                cmd     = horz_cmd;
                cmd_rdy = 1'b1;
                if (last_move) resp = 8'hA5;
            end
            WAIT_H: begin
                cmd = horz_cmd;
                if (last_move) resp = 8'hA5;
            end
            default: begin
                cmd = cmd_UART;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mv_indx   <= 5'd0;
            tour_done <= 1'b0;
        end else begin
            state     <= nxt_state;
            tour_done <= done_set;
            if (indx_clr)
                mv_indx <= 5'd0;
            else if (indx_inc)
                mv_indx <= mv_indx + 5'd1;
        end
    end

`ifdef TOUR_CMD_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tour_err <= 1'b0;
        else if (state == IDLE && start_tour)
            tour_err <= 1'b0;
        else if (err_set)
            tour_err <= 1'b1;
    end
`endif

    assign state_dbg = state;

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Directed self-checking bench for tour_cmd_seq: UART passthrough, leg decode, full tour, spurious events.
// Build with +define+TOUR_CMD_ERR_EN to exercise the abort path instead of the zero-offset path.
module tb_tour_cmd_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_tour = 1'b0;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART = 16'h0000;
    logic        cmd_rdy_UART = 1'b0;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp = 1'b0;
    logic        clr_cmd_rdy_UART;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic [7:0]  resp;
    logic        tour_done;
    logic [2:0]  state_dbg;
`ifdef TOUR_CMD_ERR_EN
    logic        tour_err;
`endif

    logic [7:0]  move_tab [0:31];
    logic [15:0] exp_q [$];
    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    int          done_base;

    // Solver model: the move presented is whatever the table holds at the DUT's index.
    assign move = move_tab[mv_indx];

    tour_cmd_seq dut (
        .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .move(move),
        .mv_indx(mv_indx), .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART),
        .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp),
        .clr_cmd_rdy_UART(clr_cmd_rdy_UART), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .resp(resp), .tour_done(tour_done),
`ifdef TOUR_CMD_ERR_EN
        .tour_err(tour_err),
`endif
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (tour_done) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected pair {vertical leg, horizontal leg} for one solver move.
    function automatic logic [31:0] legs(input logic [7:0] m);
        int dx, dy;
        logic [15:0] v, h;
        case (m)
            8'h01: begin dx = -1; dy =  2; end
            8'h02: begin dx =  1; dy =  2; end
            8'h04: begin dx = -2; dy =  1; end
            8'h08: begin dx = -2; dy = -1; end
            8'h10: begin dx = -1; dy = -2; end
            8'h20: begin dx =  1; dy = -2; end
            8'h40: begin dx =  2; dy = -1; end
            8'h80: begin dx =  2; dy =  1; end
            default: begin dx = 0; dy = 0; end
        endcase
        v = {4'h2, (dy < 0) ? 8'h7F : 8'h00, 4'((dy < 0) ? -dy : dy)};
        h = {4'h3, (dx < 0) ? 8'h3F : 8'hBF, 4'((dx < 0) ? -dx : dx)};
        return {v, h};
    endfunction

    task automatic fill_tab(input logic [7:0] m);
        for (int i = 0; i < 32; i++) move_tab[i] = m;
    endtask

    task automatic push_move(input logic [7:0] m);
        logic [31:0] p;
        p = legs(m);
        exp_q.push_back(p[31:16]);
        exp_q.push_back(p[15:0]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start_tour = 1'b1;
        @(negedge clk);
        start_tour = 1'b0;
    endtask

    // Consumer: waits (bounded) for a leg, checks it against the queue, accepts, responds after dly cycles.
    task automatic do_leg(input string tag, input int dly);
        int n;
        logic [15:0] e;
        n = 0;
        while (!cmd_rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rdy"}, cmd_rdy, 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hFFFF;
        check({tag, "_cmd"}, cmd, e);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        check({tag, "_rdy_low"}, cmd_rdy, 0);
        repeat (dly) @(negedge clk);
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
    endtask

    initial begin
        fill_tab(8'h01);
        do_reset();

        // Reset state and UART passthrough
        check("rst_state", state_dbg, 0);
        check("rst_indx", mv_indx, 0);
        check("rst_done", tour_done, 0);
        cmd_UART = 16'h2055; cmd_rdy_UART = 1'b1; clr_cmd_rdy = 1'b1;
        #1;
        check("pt_cmd", cmd, 16'h2055);
        check("pt_rdy", cmd_rdy, 1);
        check("pt_clr", clr_cmd_rdy_UART, 1);
        check("pt_resp", resp, 8'hA5);
        @(negedge clk);
        cmd_rdy_UART = 1'b0; clr_cmd_rdy = 1'b0;
        #1;
        check("pt_rdy_off", cmd_rdy, 0);
        @(negedge clk);

        // Single move 8'h01: first leg one cycle after start_tour
        pulse_start();
        check("m01_latency", cmd_rdy, 1);
        check("m01_resp", resp, 8'h5A);
        check("m01_clr_uart", clr_cmd_rdy_UART, 0);
        exp_q.push_back(16'h2002);
        exp_q.push_back(16'h33F1);
        do_leg("m01_v", 0);
        do_leg("m01_h", 0);
        check("m01_indx", mv_indx, 1);
        check("m01_state", state_dbg, 1);

        // Moves 8'h40 and 8'h08 with hand-derived legs
        do_reset();
        fill_tab(8'h40);
        pulse_start();
        exp_q.push_back(16'h27F1);
        exp_q.push_back(16'h3BF2);
        do_leg("m40_v", 1);
        do_leg("m40_h", 1);
        do_reset();
        fill_tab(8'h08);
        pulse_start();
        exp_q.push_back(16'h27F1);
        exp_q.push_back(16'h33F2);
        do_leg("m08_v", 2);
        do_leg("m08_h", 2);

        // Full 24-move tour, responder delay 5
        do_reset();
        for (int i = 0; i < 24; i++) move_tab[i] = 8'h01 << ((i * 3) % 8);
        for (int i = 0; i < 24; i++) push_move(move_tab[i]);
        done_base = done_cnt;
        pulse_start();
        for (int i = 0; i < 48; i++) begin
            do_leg($sformatf("tour_%0d", i), 5);
            if (i < 47) check($sformatf("tour_nodone_%0d", i), tour_done, 0);
        end
        check("tour_done", tour_done, 1);
        check("tour_state", state_dbg, 0);
        check("tour_resp", resp, 8'hA5);
        check("tour_q_empty", exp_q.size(), 0);
        @(negedge clk);
        check("tour_done_pulse", tour_done, 0);
        check("tour_done_cnt", done_cnt - done_base, 1);

        // Spurious events mid-tour
        do_reset();
        fill_tab(8'h01);
        pulse_start();
        for (int i = 0; i < 7; i++) push_move(8'h01);
        for (int i = 0; i < 14; i++) do_leg($sformatf("sp_%0d", i), 0);
        check("sp_indx7", mv_indx, 7);
        pulse_start();
        check("sp_start_indx", mv_indx, 7);
        check("sp_start_state", state_dbg, 1);
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        check("sp_resp_vert", state_dbg, 1);
        check("sp_resp_rdy", cmd_rdy, 1);
        clr_cmd_rdy = 1'b1; send_resp = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0; send_resp = 1'b0;
        check("sp_both", state_dbg, 2);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        check("sp_clr_wait", state_dbg, 2);
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        check("sp_horz_cmd", cmd, 16'h33F1);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        check("sp_wait_h", state_dbg, 4);
        done_base = done_cnt;
        rst_n = 1'b0;
        #1;
        check("sp_rst_state", state_dbg, 0);
        check("sp_rst_indx", mv_indx, 0);
        cmd_rdy_UART = 1'b1;
        #1;
        check("sp_rst_rdy1", cmd_rdy, 1);
        cmd_rdy_UART = 1'b0;
        #1;
        check("sp_rst_rdy0", cmd_rdy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("sp_rst_nodone", done_cnt - done_base, 0);

        // Non-one-hot move at index 4
        do_reset();
        fill_tab(8'h01);
        move_tab[4] = 8'h03;
        pulse_start();
        for (int i = 0; i < 4; i++) push_move(8'h01);
        for (int i = 0; i < 8; i++) do_leg($sformatf("bad_%0d", i), 0);
        check("bad_indx", mv_indx, 4);
`ifdef TOUR_CMD_ERR_EN
        done_base = done_cnt;
        check("err_no_rdy", cmd_rdy, 0);
        @(negedge clk);
        check("err_state", state_dbg, 0);
        check("err_flag", tour_err, 1);
        check("err_nodone", done_cnt - done_base, 0);
        pulse_start();
        check("err_clear", tour_err, 0);
        check("err_restart", state_dbg, 1);
`else
        exp_q.push_back(16'h2000);
        exp_q.push_back(16'h3BF0);
        do_leg("zero_v", 0);
        do_leg("zero_h", 0);
        check("zero_indx", mv_indx, 5);
`endif
        do_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
